// File: rtl/gate_alu_pipe.sv
// Gate ALU with valid/ready handshakes: bitwise mode, one result per beat;
// reduce mode, one result per REDUCE_LEN beats.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready, mode, op[2:0], x, y
//   out_valid/out_ready, z
//   busy (state != S_IDLE)
module gate_alu_pipe #(
  parameter int WIDTH      = 8,
  parameter int REDUCE_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             busy
);

  localparam int CW = $clog2(REDUCE_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_OUT
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] z_n;
  logic             ov_n;
  logic [2:0]       op_q, op_n;
  logic             accept;
  logic             consume;

  function automatic logic [WIDTH-1:0] f_op(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    r = a;
    unique case (o)
      3'b000: r = a & b;
      3'b001: r = ~(a & b);
      3'b010: r = a | b;
      3'b011: r = ~(a | b);
      3'b100: r = a ^ b;
      3'b101: r = ~(a ^ b);
      3'b110: r = ~a;
      3'b111: r = a;
      default: r = a;
    endcase
    return r;
  endfunction

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    z_n     = z;
    ov_n    = out_valid;
    op_n    = op_q;
    if (consume) ov_n = 1'b0;
    unique case (state)
      S_IDLE, S_OUT: begin
        if (accept) begin
          if (!mode) begin
            z_n     = f_op(op, x, y);
            ov_n    = 1'b1;
            state_n = S_OUT;
          end else begin
            // op is latched so later beats of the group ignore it
            op_n    = op;
            acc_n   = f_op(op, x, y);
            cnt_n   = CW'(1);
            state_n = S_ACC;
          end
        end else if (consume) begin
          state_n = S_IDLE;
        end
      end
      S_ACC: begin
        if (accept) begin
          acc_n = f_op(op_q, acc, x);
          if (cnt == CW'(REDUCE_LEN - 1)) begin
            z_n     = acc_n;
            ov_n    = 1'b1;
            cnt_n   = '0;
            state_n = S_OUT;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      z         <= '0;
      out_valid <= 1'b0;
      op_q      <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      z         <= z_n;
      out_valid <= ov_n;
      op_q      <= op_n;
    end
  end

endmodule

// File: tb/tb_gate_alu_pipe.sv
// Self-checking bench for gate_alu_pipe: vector table plus scoreboard
// for WIDTH=8, truth-table sweep on a WIDTH=1 instance.
module tb_gate_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic [2:0] op;
  logic [7:0] x;
  logic [7:0] y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] z;
  logic       busy;

  logic       v1;
  logic       r1;
  logic       m1;
  logic [2:0] op1;
  logic [0:0] x1;
  logic [0:0] y1;
  logic       ov1;
  logic       or1;
  logic [0:0] z1;
  logic       b1;

  int total = 0;
  int bad   = 0;

  logic [7:0] sbq[$];

  typedef struct {
    logic       m;
    logic [2:0] o;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e;
  } vec_t;

  vec_t       tab[8];
  logic [3:0] lut[8];

  always #5 clk = ~clk;

  gate_alu_pipe #(.WIDTH(8), .REDUCE_LEN(4)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .op(op), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .busy(busy)
  );

  gate_alu_pipe #(.WIDTH(1), .REDUCE_LEN(4)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_ready(r1),
    .mode(m1), .op(op1), .x(x1), .y(y1),
    .out_valid(ov1), .out_ready(or1),
    .z(z1), .busy(b1)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic send(input logic       m,
                      input logic [2:0] o,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic       push,
                      input logic [7:0] e);
    logic ok;
    mode     = m;
    op       = o;
    x        = a;
    y        = b;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_ready", ok, 1);
    if (push && ok) sbq.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got %0h want none", z);
        end else begin
          chk("sb_z", z, sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tab[0] = '{1'b0, 3'b000, 8'hF0, 8'h3C, 8'h30};
    tab[1] = '{1'b0, 3'b001, 8'hF0, 8'h3C, 8'hCF};
    tab[2] = '{1'b0, 3'b010, 8'hA0, 8'h05, 8'hA5};
    tab[3] = '{1'b0, 3'b011, 8'hA0, 8'h05, 8'h5A};
    tab[4] = '{1'b0, 3'b100, 8'hFF, 8'h0F, 8'hF0};
    tab[5] = '{1'b0, 3'b101, 8'hFF, 8'h0F, 8'h0F};
    tab[6] = '{1'b0, 3'b110, 8'h3C, 8'hAA, 8'hC3};
    tab[7] = '{1'b0, 3'b111, 8'h3C, 8'h55, 8'h3C};
    // bit index is {x,y}
    lut[0] = 4'b1000;
    lut[1] = 4'b0111;
    lut[2] = 4'b1110;
    lut[3] = 4'b0001;
    lut[4] = 4'b0110;
    lut[5] = 4'b1001;
    lut[6] = 4'b0011;
    lut[7] = 4'b1100;

    rst       = 1'b1;
    in_valid  = 1'b0;
    mode      = 1'b0;
    op        = 3'b000;
    x         = 8'h00;
    y         = 8'h00;
    out_ready = 1'b1;
    v1        = 1'b0;
    m1        = 1'b0;
    op1       = 3'b000;
    x1        = 1'b0;
    y1        = 1'b0;
    or1       = 1'b1;

    mid();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_z", z, 0);
    chk("rst_in_ready1", r1, 0);
    tick();
    rst = 1'b0;

    // basic AND: latency 1, single-cycle valid
    send(1'b0, 3'b000, 8'hF0, 8'h3C, 1'b1, 8'h30);
    mid();
    chk("and_ov", out_valid, 1);
    chk("and_z", z, 8'h30);
    mid();
    chk("and_ov_clr", out_valid, 0);
    tick();

    for (int i = 0; i < 8; i++)
      send(tab[i].m, tab[i].o, tab[i].a, tab[i].b, 1'b1, tab[i].e);
    tick();

    // WIDTH=1 truth-table sweep
    for (int o = 0; o < 8; o++) begin
      for (int k = 0; k < 4; k++) begin
        op1 = o[2:0];
        x1  = k[1];
        y1  = k[0];
        v1  = 1'b1;
        tick();
        v1  = 1'b0;
        mid();
        chk($sformatf("w1_op%0d_k%0d", o, k), z1, lut[o][k]);
      end
    end
    chk("w1_ov", ov1, 1);
    tick();

    // backpressure stall
    out_ready = 1'b0;
    send(1'b0, 3'b010, 8'h12, 8'h34, 1'b1, 8'h36);
    mode     = 1'b0;
    op       = 3'b100;
    x        = 8'hAA;
    y        = 8'h55;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("stall_rdy", in_ready, 0);
      chk("stall_ov", out_valid, 1);
      chk("stall_z", z, 8'h36);
    end
    tick();
    out_ready = 1'b1;
    mid();
    chk("stall_rel_rdy", in_ready, 1);
    sbq.push_back(8'hFF);
    tick();
    in_valid = 1'b0;
    mid();
    chk("stall_next_ov", out_valid, 1);
    chk("stall_next_z", z, 8'hFF);
    mid();
    chk("stall_drain", out_valid, 0);
    tick();

    // reduce XOR; later beats carry junk mode/op/y that must be ignored
    send(1'b1, 3'b100, 8'h01, 8'h02, 1'b0, 8'h00);
    mid();
    chk("xr_busy1", busy, 1);
    chk("xr_ov1", out_valid, 0);
    tick();
    send(1'b0, 3'b000, 8'h04, 8'hFF, 1'b0, 8'h00);
    mid();
    chk("xr_ov2", out_valid, 0);
    tick();
    send(1'b0, 3'b011, 8'h08, 8'h00, 1'b0, 8'h00);
    mid();
    chk("xr_ov3", out_valid, 0);
    chk("xr_busy3", busy, 1);
    tick();
    send(1'b0, 3'b000, 8'h10, 8'h00, 1'b1, 8'h1F);
    mid();
    chk("xr_ov4", out_valid, 1);
    chk("xr_busy4", busy, 1);
    chk("xr_z", z, 8'h1F);
    tick();
    mid();
    chk("xr_ov_clr", out_valid, 0);
    chk("xr_busy_clr", busy, 0);
    tick();

    // reset mid-group, then fresh OR group
    send(1'b1, 3'b000, 8'hFF, 8'h0F, 1'b0, 8'h00);
    send(1'b0, 3'b000, 8'h3C, 8'h00, 1'b0, 8'h00);
    rst = 1'b1;
    mid();
    chk("mrst_rdy", in_ready, 0);
    tick();
    rst = 1'b0;
    mid();
    chk("mrst_ov", out_valid, 0);
    chk("mrst_busy", busy, 0);
    tick();
    send(1'b1, 3'b010, 8'h01, 8'h02, 1'b0, 8'h00);
    send(1'b1, 3'b000, 8'h04, 8'h00, 1'b0, 8'h00);
    send(1'b1, 3'b000, 8'h08, 8'h00, 1'b0, 8'h00);
    send(1'b1, 3'b000, 8'h80, 8'h00, 1'b1, 8'h8F);
    mid();
    chk("or_ov", out_valid, 1);
    tick();

    // reduce NOT: each beat inverts acc
    send(1'b1, 3'b110, 8'h0F, 8'hAA, 1'b0, 8'h00);
    send(1'b1, 3'b000, 8'h77, 8'h00, 1'b0, 8'h00);
    send(1'b1, 3'b000, 8'h33, 8'h00, 1'b0, 8'h00);
    send(1'b1, 3'b000, 8'h11, 8'h00, 1'b1, 8'h0F);
    mid();
    chk("not_z", z, 8'h0F);
    tick();

    // streaming XOR, no bubbles
    mode     = 1'b0;
    op       = 3'b100;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      unique case (i)
        0: begin x = 8'h11; y = 8'h22; end
        1: begin x = 8'h0F; y = 8'hF0; end
        2: begin x = 8'hAA; y = 8'hAA; end
        default: begin x = 8'h81; y = 8'h18; end
      endcase
      mid();
      chk("strm_rdy", in_ready, 1);
      if (i > 0) chk("strm_ov", out_valid, 1);
      unique case (i)
        0: sbq.push_back(8'h33);
        1: sbq.push_back(8'hFF);
        2: sbq.push_back(8'h00);
        default: sbq.push_back(8'h99);
      endcase
      tick();
    end
    in_valid = 1'b0;
    mid();
    chk("strm_ov_last", out_valid, 1);
    tick();
    mid();
    chk("strm_ov_end", out_valid, 0);

    repeat (3) tick();
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_alu_pipe.md
GATE_ALU_PIPE -- requirements
Module: gate_alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter REDUCE_LEN, default 4, meaning the beats per reduce group (legal range 2..256).
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: reset, synchronous, active-high.
REQ-005 Port in_valid SHALL be an input, 1 bit: input beat present.
REQ-006 Port in_ready SHALL be an output, 1 bit: block accepts a beat this cycle.
REQ-007 Port mode SHALL be an input, 1 bit: 0 = bitwise (one result per beat), 1 = reduce (one result per REDUCE_LEN beats).
REQ-008 Port op SHALL be an input, 3 bits: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT x, 111 BUF x.
REQ-009 Ports x and y SHALL be inputs, WIDTH bits each: operands.
REQ-010 Port out_valid SHALL be an output, 1 bit: result z valid.
REQ-011 Port out_ready SHALL be an input, 1 bit: consumer accepts z.
REQ-012 Port z SHALL be an output, WIDTH bits: registered result.
REQ-013 Port busy SHALL be an output, 1 bit: high when state is not S_IDLE.

Function
REQ-014 A beat SHALL be accepted in any cycle where in_valid and in_ready are both high; an output SHALL be consumed in any cycle where out_valid and out_ready are both high.
REQ-015 in_ready SHALL equal (not rst) and ((not out_valid) or out_ready), evaluated combinationally.
REQ-016 The state machine SHALL have three states: S_IDLE, S_ACC (reduce group in progress) and S_OUT (result held).
REQ-017 In mode 0, an accepted beat SHALL load z with f_op(x,y) and set out_valid on the next edge, giving latency 1 cycle.
REQ-018 In mode 0, an accept coincident with a consume SHALL reload z with the new result and keep out_valid high, so sustained throughput is 1 result per cycle.
REQ-019 In mode 1, on the first beat, the block SHALL latch op and set acc = f_op(x,y) and cnt = 1, then move to S_ACC.
REQ-020 In S_ACC, each accepted beat SHALL set acc = f_op(acc,x), ignore y, mode and op, and increment cnt.
REQ-021 The beat that makes cnt equal REDUCE_LEN SHALL load z with the final acc, set out_valid, clear cnt and enter S_OUT.
REQ-022 No out_valid SHALL be asserted for intermediate beats of a reduce group.
REQ-023 While out_valid is high and out_ready is low, z and out_valid SHALL hold stable and in_ready SHALL be 0, so no beat is lost.
REQ-024 On consume with no coincident accept, out_valid SHALL clear and the state SHALL return to S_IDLE.
REQ-025 NOT and BUF SHALL ignore y in every mode; in reduce mode with NOT, every beat inverts acc.
REQ-026 cnt width SHALL be clog2(REDUCE_LEN+1) and cnt SHALL never wrap past REDUCE_LEN.
REQ-027 An undefined mode change mid-group SHALL have no effect; mode is sampled only on the first beat of a group.

Reset
REQ-028 While rst is high at an edge, the block SHALL force state S_IDLE, out_valid 0, z 0, acc 0 and cnt 0; busy SHALL read 0 and in_ready SHALL read 0 during rst.
REQ-029 A reset mid-group SHALL discard the partial accumulation; the first beat after rst deasserts SHALL start a new group.

Verification
REQ-030 The bench SHALL cover this case (WIDTH=8): mode 0, AND, x=F0 y=3C, out_ready=1 -> next cycle out_valid=1, z=30; following cycle out_valid=0.
REQ-031 The bench SHALL cover this case (WIDTH=1): all 8 ops x all four (x,y) pairs in mode 0 -> z matches the truth table, e.g. NAND(1,1)=0, NOR(0,0)=1, XNOR(1,0)=0, NOT x=0 -> 1.
REQ-032 The bench SHALL cover this case: mode 0 result pending with out_ready=0 for 5 cycles and in_valid=1 -> in_ready=0, z stable; out_ready=1 -> one consume, next beat accepted the same cycle.
REQ-033 The bench SHALL cover this case (REDUCE_LEN=4): mode 1, XOR, beats (x=01,y=02),(x=04),(x=08),(x=10) -> single out_valid one cycle after the 4th accept, z=1F; busy=1 from the first accept until consume.
REQ-034 The bench SHALL cover this case: mode 1 AND group, rst pulse after 2 beats -> out_valid=0, busy=0; new group OR beats (01,02),(04),(08),(80) -> z=8F.
REQ-035 The bench SHALL cover this case: mode 0 in_valid and out_ready held high for 4 cycles with XOR operand pairs -> 4 consecutive results, one per cycle, with no bubbles.
